// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared encodings for the fetch/PC unit
// Purpose: state encoding, PC select codes, fault codes and the reset NOP.
// Ports: none (package).
package fetch_pc_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SEL_IMM   = 2'b01;
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;
  localparam logic [1:0] PC_SEL_HALT  = 2'b11;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_pc_unit_next_pc_mux.sv
// rtl/fetch_pc_unit_next_pc_mux.sv - combinational next-PC selection
// Purpose: picks the candidate next PC and flags a target that is not word aligned.
// Ports:
//   pc_plus4     in  XLEN  sequential successor
//   imm_target   in  XLEN  PC+imm (branches, JAL)
//   jalr_target  in  XLEN  rs1+imm, raw
//   pc_sel       in  2     PC select code
//   branch_taken in  1     qualifies PC_SEL_IMM
//   next_pc      out XLEN  selected target
//   misaligned   out 1     next_pc[1] set
module next_pc_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_plus4,
  input  logic [XLEN-1:0] imm_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [1:0]      pc_sel,
  input  logic            branch_taken,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_sel)
      PC_SEL_IMM:  next_pc = branch_taken ? imm_target : pc_plus4;
      // JALR drops bit 0 of the computed address before use.
      PC_SEL_JALR: next_pc = {jalr_target[XLEN-1:1], 1'b0};
      default:     next_pc = pc_plus4;
    endcase
    // Bit 0 is either cleared or irrelevant here; bit 1 marks a halfword target.
    misaligned = next_pc[1];
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter, instruction register and fetch/exec sequencer
// Purpose: fetches words from instruction memory, holds the current instruction,
//   and commits the next PC from the control unit's selection.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   imem_req/imem_addr        fetch request and address (address = pc)
//   imem_rvalid/imem_rdata    returned instruction word
//   instr, instr_valid        instruction register and EXEC strobe
//   pc, pc_plus4              current PC and its link value
//   pc_sel, branch_taken      next-PC selection from control
//   imm_target, jalr_target   redirect targets from the datapath
//   end_program, ex_stall     halt request and EXEC extension
//   halted, fault             sticky halt flag and fault cause
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = '0,
  parameter int              IMEM_TIMEOUT = 0,
  parameter int              CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic [1:0]      pc_sel,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] imm_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic            end_program,
  input  logic            ex_stall,
  output logic            halted,
  output logic [1:0]      fault
);

  localparam logic [CNT_W-1:0] WD_LAST =
    CNT_W'((IMEM_TIMEOUT > 0) ? IMEM_TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic [XLEN-1:0] pc_next;
  logic [31:0]     instr_next;
  logic [1:0]      fault_next;
  logic [CNT_W-1:0] wd, wd_next;
  logic [XLEN-1:0] mux_pc;
  logic            mux_misaligned;

  assign pc_plus4 = pc + XLEN'(4);

  next_pc_mux #(.XLEN(XLEN)) u_next_pc_mux (
    .pc_plus4     (pc_plus4),
    .imm_target   (imm_target),
    .jalr_target  (jalr_target),
    .pc_sel       (pc_sel),
    .branch_taken (branch_taken),
    .next_pc      (mux_pc),
    .misaligned   (mux_misaligned)
  );

  // Handshake outputs decode from state alone, so reset drops them immediately
  // and no input reaches them combinationally.
  assign imem_req    = (state == ST_FETCH);
  assign instr_valid = (state == ST_EXEC);
  assign halted      = (state == ST_HALT);
  assign imem_addr   = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      instr <= NOP_INSTR;
      fault <= FAULT_NONE;
      wd    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      instr <= instr_next;
      fault <= fault_next;
      wd    <= wd_next;
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    instr_next = instr;
    fault_next = fault;
    wd_next    = wd;
    unique case (state)
      ST_IDLE: state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_rvalid) begin
          instr_next = imem_rdata;
          wd_next    = '0;
          state_next = ST_EXEC;
        end else if (IMEM_TIMEOUT != 0 && wd == WD_LAST) begin
          fault_next = FAULT_TIMEOUT;
          state_next = ST_HALT;
        end else begin
          wd_next = wd + 1'b1;
        end
      end
      ST_EXEC: begin
        // A stall freezes everything, including a pending halt request.
        if (!ex_stall) begin
          if (end_program || pc_sel == PC_SEL_HALT) begin
            state_next = ST_HALT;
          end else if (mux_misaligned) begin
            fault_next = FAULT_MISALIGN;
            state_next = ST_HALT;
          end else begin
            pc_next    = mux_pc;
            state_next = ST_FETCH;
          end
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;
  import fetch_pc_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [1:0]  pc_sel;
  logic        branch_taken;
  logic [31:0] imm_target;
  logic [31:0] jalr_target;
  logic        end_program;
  logic        ex_stall;
  logic        halted;
  logic [1:0]  fault;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .XLEN(32), .RESET_PC(32'h0), .IMEM_TIMEOUT(8), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid),
    .pc(pc), .pc_plus4(pc_plus4),
    .pc_sel(pc_sel), .branch_taken(branch_taken),
    .imm_target(imm_target), .jalr_target(jalr_target),
    .end_program(end_program), .ex_stall(ex_stall),
    .halted(halted), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'h0;
    pc_sel       = PC_SEL_PLUS4;
    branch_taken = 1'b0;
    imm_target   = 32'h0;
    jalr_target  = 32'h0;
    end_program  = 1'b0;
    ex_stall     = 1'b0;
  endtask

  // Leaves the bench at a falling edge right after reset release (DUT in IDLE).
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge of the EXEC cycle.
  task automatic do_fetch(input logic [31:0] word);
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (imem_req !== 1'b1) check("fetch_wait", {31'h0, imem_req}, 32'h1);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    @(negedge clk);
  endtask

  // Called at a falling edge in EXEC; applies one redirect decision.
  task automatic do_exec(input logic [1:0] sel, input logic taken,
                         input logic [31:0] imm, input logic [31:0] jalr);
    pc_sel       = sel;
    branch_taken = taken;
    imm_target   = imm;
    jalr_target  = jalr;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int reqs;

    // Reset state and first instruction
    rst_n = 1'b0;
    clear_inputs();
    #12;
    check("rst_req",    {31'h0, imem_req},    32'h0);
    check("rst_ivalid", {31'h0, instr_valid}, 32'h0);
    check("rst_pc",     pc,                   32'h0);
    check("rst_instr",  instr,                32'h0000_0013);
    check("rst_halted", {31'h0, halted},      32'h0);
    check("rst_fault",  {30'h0, fault},       32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0050_0093;
    check("idle_req", {31'h0, imem_req}, 32'h0);
    @(negedge clk);
    check("c1_req",  {31'h0, imem_req}, 32'h1);
    check("c1_addr", imem_addr,         32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("c2_ivalid", {31'h0, instr_valid}, 32'h1);
    check("c2_instr",  instr,                32'h0050_0093);
    check("c2_pc",     pc,                   32'h0);
    check("c2_pc4",    pc_plus4,             32'h4);
    check("c2_req",    {31'h0, imem_req},    32'h0);
    do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    check("seq_addr", imem_addr,         32'h4);
    check("seq_req",  {31'h0, imem_req}, 32'h1);

    // Walk to pc=0x10
    do_fetch(NOP_INSTR); do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    do_fetch(NOP_INSTR); do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    do_fetch(NOP_INSTR); do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    check("walk_addr", imem_addr, 32'h10);

    // Branch taken / not taken
    do_fetch(NOP_INSTR); do_exec(PC_SEL_IMM, 1'b1, 32'h40, 32'h0);
    check("br_taken", imem_addr, 32'h40);
    do_fetch(NOP_INSTR); do_exec(PC_SEL_IMM, 1'b1, 32'h10, 32'h0);
    do_fetch(NOP_INSTR); do_exec(PC_SEL_IMM, 1'b0, 32'h40, 32'h0);
    check("br_not_taken", imem_addr, 32'h14);

    // Wrap at top of address space (JALR also clears bit 0)
    do_fetch(NOP_INSTR); do_exec(PC_SEL_JALR, 1'b0, 32'h0, 32'hFFFF_FFFD);
    check("jalr_top", imem_addr, 32'hFFFF_FFFC);
    do_fetch(NOP_INSTR);
    check("wrap_pc4", pc_plus4, 32'h0);
    do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // JALR aligned and misaligned
    do_fetch(NOP_INSTR); do_exec(PC_SEL_JALR, 1'b0, 32'h0, 32'h101);
    check("jalr_lsb", imem_addr, 32'h100);
    do_fetch(NOP_INSTR); do_exec(PC_SEL_JALR, 1'b0, 32'h0, 32'h102);
    check("mis_halted", {31'h0, halted},      32'h1);
    check("mis_fault",  {30'h0, fault},       32'h1);
    check("mis_pc",     pc,                   32'h100);
    check("mis_ivalid", {31'h0, instr_valid}, 32'h0);
    reqs = 0;
    for (int i = 0; i < 4; i++) begin
      if (imem_req === 1'b1) reqs++;
      @(negedge clk);
    end
    check("mis_no_req", reqs, 32'h0);

    // Stall has priority over end_program
    do_reset();
    do_fetch(32'h0000_0073);
    ex_stall    = 1'b1;
    end_program = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_ivalid", {31'h0, instr_valid}, 32'h1);
      check("stall_halted", {31'h0, halted},      32'h0);
      if (i == 2) ex_stall = 1'b0;
      @(negedge clk);
    end
    end_program = 1'b0;
    check("end_halted", {31'h0, halted},      32'h1);
    check("end_ivalid", {31'h0, instr_valid}, 32'h0);
    check("end_fault",  {30'h0, fault},       32'h0);
    check("end_pc",     pc,                   32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pulse_halted", {31'h0, halted}, 32'h0);
    check("rst_pulse_pc",     pc,              32'h0);

    // Fetch timeout
    do_reset();
    reqs = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req === 1'b1) reqs++;
      @(negedge clk);
    end
    check("to_req_cycles", reqs,            32'd8);
    check("to_halted",     {31'h0, halted}, 32'h1);
    check("to_fault",      {30'h0, fault},  32'h2);

    // Asynchronous reset mid-FETCH, stale rvalid in IDLE
    do_reset();
    do_fetch(32'h1234_5678);
    check("mf_instr", instr, 32'h1234_5678);
    do_exec(PC_SEL_PLUS4, 1'b0, 32'h0, 32'h0);
    check("mf_fetch_addr", imem_addr, 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mf_req",   {31'h0, imem_req}, 32'h0);
    check("mf_pc",    pc,                32'h0);
    check("mf_instr_nop", instr,         32'h0000_0013);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 imem_rvalid = 1'b0;
    @(negedge clk);
    check("stale_req",   {31'h0, imem_req}, 32'h1);
    check("stale_instr", instr,             32'h0000_0013);
    @(negedge clk);
    check("stale_instr2", instr,                32'h0000_0013);
    check("stale_ivalid", {31'h0, instr_valid}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
